// File: rtl/move_engine_if.sv
// Move/load request bus and committed-board outputs of the 2048 game-state engine.
interface move_engine_if;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        move_ready;
   logic        load_en;
   logic [63:0] load_board;
   logic [63:0] board_state;
   logic [19:0] score;
   logic        win;
   logic        game_over;

   modport master (
      output move_valid, move_dir, load_en, load_board,
      input  move_ready, board_state, score, win, game_over
   );

   modport slave (
      input  move_valid, move_dir, load_en, load_board,
      output move_ready, board_state, score, win, game_over
   );
endinterface

// File: rtl/move_engine.sv
// 2048 game-state engine: owns the 4x4 board, slides/merges one line per cycle,
// spawns an LFSR-chosen tile and commits each new board atomically.
module move_engine #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter bit          SPAWN_EN  = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   move_engine_if.slave bus
);
   typedef enum logic [2:0] {S_INIT0, S_INIT1, S_IDLE, S_SLIDE, S_SPAWN, S_COMMIT} state_t;
   typedef struct packed {
      logic [15:0] cells;
      logic [19:0] gain;
   } slide_t;

   state_t      r_state, r_after;
   logic [63:0] r_board, r_work;
   logic [19:0] r_score, r_pending;
   logic        r_win, r_go, r_ready;
   logic [15:0] r_lfsr;
   logic [1:0]  r_dir, r_line;
   logic [3:0]  r_probe, r_probes;

   logic [15:0] w_lfsr_next;
   logic [15:0] w_line_in;
   slide_t      w_slide;
   logic [63:0] w_work_slid;
   logic [3:0]  w_probe_cell;
   logic [20:0] w_score_sum;
   logic [19:0] w_score_sat;
   logic        w_work_win, w_work_go, w_load_win, w_load_go;

   // Cell index {row,col} of position pos (front = 0) within line ln for a direction.
   function automatic logic [3:0] f_idx(input logic [1:0] dir, input logic [1:0] ln,
                                        input logic [1:0] pos);
      case (dir)
         2'd0:    f_idx = {ln, pos};
         2'd1:    f_idx = {ln, ~pos};
         2'd2:    f_idx = {pos, ln};
         default: f_idx = {~pos, ln};
      endcase
   endfunction

   function automatic slide_t f_slide(input logic [15:0] v);
      logic [3:0] c [5];
      logic [3:0] r [4];
      logic [2:0] n, o;
      logic       skip;
      slide_t     res;
      for (int i = 0; i < 5; i++) c[i] = 4'd0;
      for (int i = 0; i < 4; i++) r[i] = 4'd0;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[4*i +: 4] != 4'd0) begin
            c[n] = v[4*i +: 4];
            n    = n + 3'd1;
         end
      end
      // c[4] stays zero, so the last tile never finds a partner.
      skip     = 1'b0;
      o        = 3'd0;
      res.gain = 20'd0;
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (c[i] != 4'd0) begin
            if (c[i] == c[i+1] && c[i] != 4'd15) begin
               r[o[1:0]] = c[i] + 4'd1;
               res.gain  = res.gain + (20'd1 << (c[i] + 4'd1));
               skip      = 1'b1;
            end else begin
               r[o[1:0]] = c[i];
            end
            o = o + 3'd1;
         end
      end
      for (int i = 0; i < 4; i++) res.cells[4*i +: 4] = r[i];
      return res;
   endfunction

   function automatic logic f_has_win(input logic [63:0] b);
      f_has_win = 1'b0;
      for (int i = 0; i < 16; i++)
         if (b[4*i +: 4] == 4'd11) f_has_win = 1'b1;
   endfunction

   function automatic logic f_stuck(input logic [63:0] b);
      f_stuck = 1'b1;
      for (int i = 0; i < 16; i++)
         if (b[4*i +: 4] == 4'd0) f_stuck = 1'b0;
      for (int rw = 0; rw < 4; rw++)
         for (int cl = 0; cl < 3; cl++)
            if (b[16*rw + 4*cl +: 4] == b[16*rw + 4*cl + 4 +: 4]) f_stuck = 1'b0;
      for (int i = 0; i < 12; i++)
         if (b[4*i +: 4] == b[4*i + 16 +: 4]) f_stuck = 1'b0;
   endfunction

   // NOTE: every signal driven in always_comb gets a full default first, so no latch can form.
   always_comb begin
      w_line_in   = '0;
      w_work_slid = r_work;
      for (int j = 0; j < 4; j++)
         w_line_in[4*j +: 4] = r_work[{f_idx(r_dir, r_line, 2'(j)), 2'b00} +: 4];
      w_slide = f_slide(w_line_in);
      for (int j = 0; j < 4; j++)
         w_work_slid[{f_idx(r_dir, r_line, 2'(j)), 2'b00} +: 4] = w_slide.cells[4*j +: 4];
   end

   assign w_lfsr_next  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_probe_cell = r_work[{r_probe, 2'b00} +: 4];
   assign w_score_sum  = {1'b0, r_score} + {1'b0, r_pending};
   assign w_score_sat  = w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
   assign w_work_win   = f_has_win(r_work);
   assign w_work_go    = f_stuck(r_work);
   assign w_load_win   = f_has_win(bus.load_board);
   assign w_load_go    = f_stuck(bus.load_board);

   // NOTE: sequential state uses non-blocking assignments only; the board register is
   // reset explicitly like every other register because the display reads it directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_INIT0;
         r_after   <= S_IDLE;
         r_board   <= '0;
         r_work    <= '0;
         r_score   <= '0;
         r_pending <= '0;
         r_win     <= 1'b0;
         r_go      <= 1'b0;
         r_ready   <= 1'b0;
         r_lfsr    <= LFSR_SEED;
         r_dir     <= '0;
         r_line    <= '0;
         r_probe   <= '0;
         r_probes  <= '0;
      end else begin
         r_lfsr <= w_lfsr_next;
         case (r_state)
            S_INIT0, S_INIT1: begin
               if (SPAWN_EN) begin
                  r_work   <= r_board;
                  r_probe  <= r_lfsr[3:0];
                  r_probes <= '0;
                  r_after  <= (r_state == S_INIT0) ? S_INIT1 : S_IDLE;
                  r_state  <= S_SPAWN;
               end else begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (bus.load_en) begin
                  r_board <= bus.load_board;
                  r_work  <= bus.load_board;
                  r_win   <= w_load_win;
                  r_go    <= w_load_go;
                  r_ready <= !w_load_go;
               end else if (bus.move_valid && r_ready) begin
                  r_dir     <= bus.move_dir;
                  r_work    <= r_board;
                  r_line    <= '0;
                  r_pending <= '0;
                  r_after   <= S_IDLE;
                  r_ready   <= 1'b0;
                  r_state   <= S_SLIDE;
               end
            end
            S_SLIDE: begin
               r_work    <= w_work_slid;
               r_pending <= r_pending + w_slide.gain;
               r_line    <= r_line + 2'd1;
               if (r_line == 2'd3) begin
                  if (w_work_slid == r_board) begin
                     r_state <= S_IDLE;
                     r_ready <= 1'b1;
                  end else if (SPAWN_EN) begin
                     r_probe  <= r_lfsr[3:0];
                     r_probes <= '0;
                     r_state  <= S_SPAWN;
                  end else begin
                     r_state <= S_COMMIT;
                  end
               end
            end
            S_SPAWN: begin
               if (w_probe_cell == 4'd0) begin
                  r_work[{r_probe, 2'b00} +: 4] <= (r_lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
                  r_state <= S_COMMIT;
               end else begin
                  r_probe  <= r_probe + 4'd1;
                  r_probes <= r_probes + 4'd1;
                  if (r_probes == 4'd15) r_state <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               r_board   <= r_work;
               r_score   <= w_score_sat;
               r_pending <= '0;
               r_win     <= r_win | w_work_win;
               r_go      <= r_go | w_work_go;
               r_ready   <= (r_after == S_IDLE) && !(r_go || w_work_go);
               r_state   <= r_after;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.move_ready  = r_ready;
   assign bus.board_state = r_board;
   assign bus.score       = r_score;
   assign bus.win         = r_win;
   assign bus.game_over   = r_go;
endmodule

// File: tb/tb_move_engine.sv
// Scoreboard bench for move_engine: one instance without spawns, one with spawns.
module tb_move_engine;
   localparam logic [15:0] SEED = 16'hACE1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   bit          sel = 1'b0;
   logic        move_valid = 1'b0;
   logic [1:0]  move_dir = 2'd0;
   logic        load_en = 1'b0;
   logic [63:0] load_board = 64'd0;

   always #5 clk = ~clk;

   move_engine_if bus0 ();
   move_engine_if bus1 ();

   assign bus0.move_valid = move_valid & ~sel;
   assign bus0.move_dir   = move_dir;
   assign bus0.load_en    = load_en & ~sel;
   assign bus0.load_board = load_board;
   assign bus1.move_valid = move_valid & sel;
   assign bus1.move_dir   = move_dir;
   assign bus1.load_en    = load_en & sel;
   assign bus1.load_board = load_board;

   move_engine #(.LFSR_SEED(SEED), .SPAWN_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   move_engine #(.LFSR_SEED(SEED), .SPAWN_EN(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   typedef struct packed {
      logic [63:0] board;
      logic [19:0] score;
      logic        win;
      logic        go;
      logic [7:0]  lat;
   } exp_t;

   exp_t        exp_q [$];
   int          total = 0;
   int          bad = 0;
   logic [15:0] m_lfsr;
   logic [63:0] cur_board [2];
   logic [19:0] cur_score [2];
   logic        cur_win [2];
   logic        cur_go [2];

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   function automatic logic [15:0] lfsr_adv(input logic [15:0] l, input int n);
      logic [15:0] x;
      x = l;
      for (int k = 0; k < n; k++) x = lfsr_step(x);
      return x;
   endfunction

   always @(posedge clk) m_lfsr <= rst ? SEED : lfsr_step(m_lfsr);

   function automatic logic [63:0] get_board();
      return sel ? bus1.board_state : bus0.board_state;
   endfunction
   function automatic logic [19:0] get_score();
      return sel ? bus1.score : bus0.score;
   endfunction
   function automatic logic get_win();
      return sel ? bus1.win : bus0.win;
   endfunction
   function automatic logic get_go();
      return sel ? bus1.game_over : bus0.game_over;
   endfunction
   function automatic logic get_ready();
      return sel ? bus1.move_ready : bus0.move_ready;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
      end
   endtask

   function automatic int cell_idx(input logic [1:0] dir, input int ln, input int pos);
      case (dir)
         2'd0:    return ln * 4 + pos;
         2'd1:    return ln * 4 + (3 - pos);
         2'd2:    return pos * 4 + ln;
         default: return (3 - pos) * 4 + ln;
      endcase
   endfunction

   task automatic model_slide(input logic [63:0] b, input logic [1:0] dir,
                              output logic [63:0] nb, output logic [19:0] gain);
      int q [$];
      int o [$];
      int i;
      nb   = b;
      gain = 20'd0;
      for (int ln = 0; ln < 4; ln++) begin
         q.delete();
         o.delete();
         for (int pos = 0; pos < 4; pos++)
            if (b[4*cell_idx(dir, ln, pos) +: 4] != 4'd0) q.push_back(int'(b[4*cell_idx(dir, ln, pos) +: 4]));
         i = 0;
         while (i < q.size()) begin
            if (i + 1 < q.size() && q[i] == q[i+1] && q[i] != 15) begin
               o.push_back(q[i] + 1);
               gain = gain + 20'(1 << (q[i] + 1));
               i += 2;
            end else begin
               o.push_back(q[i]);
               i += 1;
            end
         end
         while (o.size() < 4) o.push_back(0);
         for (int pos = 0; pos < 4; pos++) nb[4*cell_idx(dir, ln, pos) +: 4] = 4'(o[pos]);
      end
   endtask

   // Probe from l_entry[3:0]; each probe cycle sees the LFSR one step further on.
   function automatic logic [63:0] model_spawn(input logic [63:0] b, input logic [15:0] l_entry,
                                               output int probes);
      logic [63:0] nb;
      logic [15:0] l;
      int          p;
      nb     = b;
      l      = l_entry;
      p      = int'(l_entry[3:0]);
      probes = 0;
      for (int k = 0; k < 16; k++) begin
         l = lfsr_step(l);
         probes++;
         if (nb[4*p +: 4] == 4'd0) begin
            nb[4*p +: 4] = (l[7:4] == 4'd0) ? 4'd2 : 4'd1;
            return nb;
         end
         p = (p + 1) % 16;
      end
      return nb;
   endfunction

   function automatic logic has11(input logic [63:0] b);
      for (int i = 0; i < 16; i++) if (b[4*i +: 4] == 4'd11) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic stuck(input logic [63:0] b);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (b[4*(r*4+c) +: 4] == 4'd0) return 1'b0;
            if (c < 3 && b[4*(r*4+c) +: 4] == b[4*(r*4+c+1) +: 4]) return 1'b0;
            if (r < 3 && b[4*(r*4+c) +: 4] == b[4*((r+1)*4+c) +: 4]) return 1'b0;
         end
      return 1'b1;
   endfunction

   function automatic int nonzero(input logic [63:0] b);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
      return n;
   endfunction

   function automatic logic [19:0] sat_add(input logic [19:0] a, input logic [19:0] g);
      logic [20:0] s;
      s = {1'b0, a} + {1'b0, g};
      return s[20] ? 20'hFFFFF : s[19:0];
   endfunction

   function automatic logic [63:0] rand_board();
      logic [63:0] b;
      int          v;
      for (int i = 0; i < 16; i++) begin
         v = int'($urandom_range(0, 5));
         b[4*i +: 4] = (v > 3) ? 4'd0 : 4'(v);
      end
      b[63:60] = 4'd0;
      return b;
   endfunction

   task automatic predict_init(input logic [15:0] la, output logic [63:0] b);
      int n1, n2;
      b = model_spawn(64'd0, la, n1);
      b = model_spawn(b, lfsr_adv(la, n1 + 2), n2);
   endtask

   // Called at a falling edge; the board is visible at the next falling edge.
   task automatic do_load(input bit s, input logic [63:0] b, input string tag);
      sel        = s;
      load_board = b;
      load_en    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load_en      = 1'b0;
      cur_board[s] = b;
      cur_win[s]   = has11(b);
      cur_go[s]    = stuck(b);
      check({tag, ".load_board"}, get_board(), b);
      check({tag, ".load_score"}, 64'(get_score()), 64'(cur_score[s]));
      check({tag, ".load_win"}, 64'(get_win()), 64'(cur_win[s]));
      check({tag, ".load_go"}, 64'(get_go()), 64'(cur_go[s]));
   endtask

   task automatic do_move(input bit s, input logic [1:0] dir, input string tag);
      exp_t        e, g;
      logic [63:0] slid;
      logic [19:0] gain;
      int          probes;
      int          lat;
      sel = s;
      check({tag, ".ready_in"}, 64'(get_ready()), 64'd1);
      model_slide(cur_board[s], dir, slid, gain);
      if (slid == cur_board[s]) begin
         e.lat = 8'd5;
      end else begin
         probes = 0;
         if (s) slid = model_spawn(slid, lfsr_adv(m_lfsr, 4), probes);
         e.lat        = 8'(6 + probes);
         cur_board[s] = slid;
         cur_score[s] = sat_add(cur_score[s], gain);
         cur_win[s]   = cur_win[s] | has11(slid);
         cur_go[s]    = cur_go[s] | stuck(slid);
      end
      e.board = cur_board[s];
      e.score = cur_score[s];
      e.win   = cur_win[s];
      e.go    = cur_go[s];
      exp_q.push_back(e);
      move_dir   = dir;
      move_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      move_valid = 1'b0;
      lat        = 1;
      while (!get_ready() && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      g = exp_q.pop_front();
      check({tag, ".latency"}, 64'(lat), 64'(g.lat));
      check({tag, ".board"}, get_board(), g.board);
      check({tag, ".score"}, 64'(get_score()), 64'(g.score));
      check({tag, ".win"}, 64'(get_win()), 64'(g.win));
      check({tag, ".go"}, 64'(get_go()), 64'(g.go));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".board"}, get_board(), 64'd0);
      check({tag, ".score"}, 64'(get_score()), 64'd0);
      check({tag, ".win"}, 64'(get_win()), 64'd0);
      check({tag, ".go"}, 64'(get_go()), 64'd0);
      check({tag, ".ready"}, 64'(get_ready()), 64'd0);
   endtask

   task automatic finish_init(input logic [15:0] la, input string tag);
      logic [63:0] b;
      int          n;
      @(negedge clk);
      sel = 1'b0;
      check({tag, ".dut0_ready"}, 64'(get_ready()), 64'd1);
      sel = 1'b1;
      check({tag, ".dut1_busy"}, 64'(get_ready()), 64'd0);
      check({tag, ".dut1_blank"}, get_board(), 64'd0);
      predict_init(la, b);
      n = 0;
      while (!get_ready() && n < 60) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".init_ready"}, 64'(get_ready()), 64'd1);
      check({tag, ".init_board"}, get_board(), b);
      check({tag, ".init_tiles"}, 64'(nonzero(get_board())), 64'd2);
      check({tag, ".init_score"}, 64'(get_score()), 64'd0);
      for (int i = 0; i < 2; i++) begin
         cur_board[i] = 64'd0;
         cur_score[i] = 20'd0;
         cur_win[i]   = 1'b0;
         cur_go[i]    = 1'b0;
      end
      cur_board[1] = b;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] la;
      logic [63:0] cb;

      repeat (3) @(negedge clk);
      sel = 1'b0;
      check_reset_outputs("rst0");
      sel = 1'b1;
      check_reset_outputs("rst1");
      rst = 1'b0;
      la  = m_lfsr;
      finish_init(la, "init");

      do_load(1'b0, 64'h1111, "l1111");
      do_move(1'b0, 2'd0, "m1111_left");
      do_load(1'b0, 64'h0211, "l1120");
      do_move(1'b0, 2'd0, "m1120_left");
      do_load(1'b0, 64'h0211, "l1120b");
      do_move(1'b0, 2'd1, "m1120_right");
      do_load(1'b0, 64'h0123, "l3210");
      do_move(1'b0, 2'd0, "m3210_nochange");

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) cb[4*(r*4+c) +: 4] = 4'(1 + ((r + c) % 2));
      do_load(1'b0, cb, "lchk");
      check("chk.ready", 64'(get_ready()), 64'd0);
      move_dir   = 2'd0;
      move_valid = 1'b1;
      repeat (8) @(negedge clk);
      move_valid = 1'b0;
      check("chk.ignored_board", get_board(), cb);
      check("chk.ignored_ready", 64'(get_ready()), 64'd0);

      do_load(1'b0, 64'hAA, "l1010");
      do_move(1'b0, 2'd0, "m1010_left");
      check("win.cell0", 64'(get_board() & 64'hF), 64'hB);

      for (int t = 0; t < 6; t++) begin
         do_load(1'b0, rand_board(), $sformatf("lrnd0_%0d", t));
         do_move(1'b0, 2'($urandom_range(0, 3)), $sformatf("mrnd0_%0d", t));
      end

      do_load(1'b1, 64'h1, "lsp");
      do_move(1'b1, 2'd1, "msp_right");
      check("sp.cell3", 64'(get_board() & 64'hF000), 64'h1000);
      check("sp.tiles", 64'(nonzero(get_board())), 64'd2);

      for (int t = 0; t < 4; t++) begin
         do_load(1'b1, rand_board(), $sformatf("lrnd1_%0d", t));
         do_move(1'b1, 2'($urandom_range(0, 3)), $sformatf("mrnd1_%0d", t));
      end

      do_load(1'b1, 64'h1, "lrst");
      move_dir   = 2'd1;
      move_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      move_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sel = 1'b1;
      check_reset_outputs("midrst1");
      sel = 1'b0;
      check_reset_outputs("midrst0");
      rst = 1'b0;
      la  = m_lfsr;
      finish_init(la, "reinit");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
